// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the single vga_adapter plot port among three drawer clients.
// A grant is held for a whole client transaction; a hold timer reclaims the port from a stuck client.
module vga_plot_arbiter #(
    parameter logic [23:0] HOLD_LIMIT = 24'd12_000_000,
    parameter int          CW         = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [2:0]  plot,
    input  logic [23:0] x_bus,
    input  logic [20:0] y_bus,
    input  logic [8:0]  color_bus,
    output logic [2:0]  grant,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        vga_plot,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [CW-1:0] last_q, last_d;
    logic [23:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [2:0]    vga_color_q, vga_color_d;
    logic          vga_plot_q, vga_plot_d;
    logic          timeout_err_q, timeout_err_d;

    logic [CW-1:0] owner, cand0, cand1, cand2, pick;
    logic          pick_vld;
    logic [7:0]    x_arr [3];
    logic [6:0]    y_arr [3];
    logic [2:0]    c_arr [3];

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] v);
        return (v >= CW'(2)) ? '0 : v + CW'(1);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            x_arr[i] = x_bus[8*i +: 8];
            y_arr[i] = y_bus[7*i +: 7];
            c_arr[i] = color_bus[3*i +: 3];
        end
    end

    always_comb begin
        owner = '0;
        if (grant_q[1])
            owner = CW'(1);
        else if (grant_q[2])
            owner = CW'(2);
    end

    always_comb begin
        cand0    = next_idx(last_q);
        cand1    = next_idx(cand0);
        cand2    = next_idx(cand1);
        pick     = '0;
        pick_vld = 1'b0;
        if (req[cand0]) begin
            pick     = cand0;
            pick_vld = 1'b1;
        end else if (req[cand1]) begin
            pick     = cand1;
            pick_vld = 1'b1;
        end else if (req[cand2]) begin
            pick     = cand2;
            pick_vld = 1'b1;
        end
    end

    // grant stays asserted through RELEASE so owner is still known there;
    // it clears on leaving RELEASE, giving exactly one grant=0 cycle (IDLE) between owners.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        hold_cnt_d    = hold_cnt_q;
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_color_d   = vga_color_q;
        vga_plot_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = 3'b001 << pick;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                vga_x_d     = x_arr[owner];
                vga_y_d     = y_arr[owner];
                vga_color_d = c_arr[owner];
                vga_plot_d  = plot[owner] & req[owner];
                if (!req[owner]) begin
                    state_d = RELEASE;
                end else if (hold_cnt_q == HOLD_LIMIT - 24'd1) begin
                    state_d       = RELEASE;
                    timeout_err_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 24'd1;
                end
            end
            RELEASE: begin
                grant_d    = '0;
                last_d     = owner;
                hold_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_q        <= CW'(2);
            hold_cnt_q    <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_color_q   <= '0;
            vga_plot_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            hold_cnt_q    <= hold_cnt_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_color_q   <= vga_color_d;
            vga_plot_q    <= vga_plot_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_color   = vga_color_q;
    assign vga_plot    = vga_plot_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule
